// File: rtl/apu_dmc_dma_responder.sv
// -----------------------------------------------------------------------------
// apu_dmc_dma_responder
//
// Bus-side responder for the APU DMC sample-fetch port. On a DMC request it
// halts the CPU at a read cycle. It then inserts a dummy cycle, plus an
// alignment cycle when the put/get parity is wrong. After that it performs
// one read on the shared CPU bus and returns the byte with a one-clock grant.
//
// Parameters
//   ADDR_W  bus address width
//   RD_LAT  clocks from o_bus_rd to valid i_bus_rdata (1..4)
//
// Ports
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_cpu_ce        one-clock pulse at the start of every CPU cycle
//   i_cpu_addr      CPU address of the current cycle
//   i_cpu_wn        CPU direction of the current cycle (1 = read)
//   o_cpu_halt      RDY-low request to the CPU
//   i_dmc_req       DMC fetch request, held until grant
//   i_dmc_addr      sample address, stable while requesting
//   o_dmc_gnt       one-clock grant; o_dmc_smpl is valid in the same clock
//   o_dmc_smpl      fetched sample, held until the next grant
//   o_bus_addr      CPU address, or the latched DMC address while owning the bus
//   o_bus_rd        one-clock read strobe for the DMA fetch
//   o_bus_own       high while the responder owns the bus
//   i_bus_rdata     bus read data
// -----------------------------------------------------------------------------
module apu_dmc_dma_responder #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_ce,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic              i_cpu_wn,
  output logic              o_cpu_halt,
  input  logic              i_dmc_req,
  input  logic [ADDR_W-1:0] i_dmc_addr,
  output logic              o_dmc_gnt,
  output logic [7:0]        o_dmc_smpl,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic              o_bus_rd,
  output logic              o_bus_own,
  input  logic [7:0]        i_bus_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_DUMMY,
    S_ALIGN,
    S_FETCH,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT);

  state_t            state;
  state_t            state_nxt;
  logic              r_get;     // put/get parity of the current CPU cycle
  logic [ADDR_W-1:0] r_addr;    // latched DMC sample address
  logic [2:0]        r_lat;     // read-latency counter, 1 in the first WAIT clock
  logic              r_gnt;
  logic [7:0]        r_smpl;
  logic              lat_done;
  logic              accept;

  assign lat_done = (r_lat == LAT_LAST);
  assign accept   = (state == S_IDLE) && i_cpu_ce && i_dmc_req;

  // NOTE: every variable driven here gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_HALT;
      S_HALT: begin
        if (i_cpu_ce) begin
          if (!i_dmc_req)    state_nxt = S_IDLE;   // abort before any bus activity
          else if (i_cpu_wn) state_nxt = S_DUMMY;  // CPU now stalled on a read
        end
      end
      // ~r_get is the parity of the cycle this ce starts.
      S_DUMMY: if (i_cpu_ce) state_nxt = (~r_get) ? S_FETCH : S_ALIGN;
      S_ALIGN: if (i_cpu_ce) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_WAIT;
      // Latency counting ignores ce; system ce spacing guarantees it finishes.
      S_WAIT:  if (lat_done) state_nxt = S_DONE;
      S_DONE:  if (i_cpu_ce) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      r_get  <= 1'b0;
      r_addr <= '0;
      r_lat  <= '0;
      r_gnt  <= 1'b0;
      r_smpl <= 8'h00;
    end else begin
      state <= state_nxt;
      if (i_cpu_ce) r_get  <= ~r_get;
      if (accept)   r_addr <= i_dmc_addr;
      if (state == S_FETCH)     r_lat <= 3'd1;
      else if (state == S_WAIT) r_lat <= r_lat + 3'd1;
      // Grant is registered together with the sample so both appear in the
      // first DONE clock.
      r_gnt <= (state == S_WAIT) && lat_done;
      if ((state == S_WAIT) && lat_done) r_smpl <= i_bus_rdata;
    end
  end

  assign o_cpu_halt = (state != S_IDLE);
  assign o_bus_own  = (state == S_FETCH) || (state == S_WAIT) || (state == S_DONE);
  assign o_bus_rd   = (state == S_FETCH);
  assign o_bus_addr = o_bus_own ? r_addr : i_cpu_addr;
  assign o_dmc_gnt  = r_gnt;
  assign o_dmc_smpl = r_smpl;

endmodule
